// File: rtl/lowp_interp_up_pkg.sv
// Shared types and helpers for the lowp_interp_up upsampling interpolator.
package lowp_interp_up_pkg;

    localparam int DEFAULT_W = 28;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2
    } interp_state_e;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lowp_interp_up_tick_div.sv
// Output-rate divider: one-cycle tick every OUT_DIV enabled clocks.
module lowp_tick_div
    import lowp_interp_up_pkg::*;
#(
    parameter int OUT_DIV = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (log2_ceil(OUT_DIV) > 0) ? log2_ceil(OUT_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tick_o  = enable_i & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lowp_interp_up.sv
// Upsampling reconstruction filter: UP_FACTOR outputs per input, paced by lowp_tick_div.
// INTERP_LINEAR_EN selects linear interpolation; otherwise each segment is a zero-order hold.
module lowp_interp_up
    import lowp_interp_up_pkg::*;
#(
    parameter int UP_FACTOR = 16,
    parameter int OUT_DIV   = 4,
    parameter int W         = DEFAULT_W
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [W-1:0] signal_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] signal_out,
    output logic                out_valid,
    output logic                underflow
);

    localparam int S = log2_ceil(UP_FACTOR);

    interp_state_e       state_q, state_d;
    logic signed [W-1:0] pend_q, pend_d;
    logic signed [W-1:0] prev_q, prev_d;
    logic signed [W-1:0] cur_q, cur_d;
    logic signed [W-1:0] out_q, out_d;
    logic                pend_full_q, pend_full_d;
    logic                out_valid_q, out_valid_d;
    logic                underflow_q, underflow_d;
    logic [S-1:0]        idx_q, idx_d;
    logic signed [W-1:0] step_val;
    logic                tick;
    logic                accept;
    logic                consume;
    logic                load_seg;

`ifdef INTERP_LINEAR_EN
    logic signed [W:0]   delta_q, delta_d;
    logic signed [W+S:0] acc_q, acc_d;

    // acc holds prev*UP_FACTOR + i*delta, so the shift floors to the interpolated sample
    assign step_val = W'(acc_q >>> S);
`else
    assign step_val = cur_q;
`endif

    lowp_tick_div #(
        .OUT_DIV(OUT_DIV)
    ) u_tick_div (
        .clock_i (clock_in),
        .reset_i (reset),
        .enable_i(enable),
        .tick_o  (tick)
    );

    assign accept     = in_valid & ~pend_full_q;
    assign in_ready   = ~pend_full_q;
    assign signal_out = out_q;
    assign out_valid  = out_valid_q;
    assign underflow  = underflow_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        underflow_d = underflow_q;
        consume     = 1'b0;
        load_seg    = 1'b0;
`ifdef INTERP_LINEAR_EN
        delta_d     = delta_q;
        acc_d       = acc_q;
`endif

        if (enable) begin
            case (state_q)
                ST_EMPTY: begin
                    if (pend_full_q) begin
                        prev_d  = pend_q;
                        consume = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        out_valid_d = 1'b1;
                        out_d       = prev_q;
                        if (pend_full_q) begin
                            load_seg = 1'b1;
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        out_valid_d = 1'b1;
                        out_d       = step_val;
                        idx_d       = idx_q + S'(1);
`ifdef INTERP_LINEAR_EN
                        acc_d       = acc_q + {{S{delta_q[W]}}, delta_q};
`endif
                        // last step of the segment: chain straight into the next one if it is waiting
                        if (&idx_q) begin
                            prev_d = cur_q;
                            if (pend_full_q) begin
                                load_seg = 1'b1;
                            end else begin
                                state_d     = ST_HOLD;
                                underflow_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        if (load_seg) begin
            consume = 1'b1;
            cur_d   = pend_q;
            idx_d   = '0;
`ifdef INTERP_LINEAR_EN
            delta_d = {pend_q[W-1], pend_q} - {prev_d[W-1], prev_d};
            acc_d   = {prev_d[W-1], prev_d, {S{1'b0}}};
`endif
        end

        if (accept) begin
            pend_d      = signal_in;
            pend_full_d = 1'b1;
        end else if (consume) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            prev_q      <= '0;
            cur_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef INTERP_LINEAR_EN
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            delta_q <= '0;
            acc_q   <= '0;
        end else begin
            delta_q <= delta_d;
            acc_q   <= acc_d;
        end
    end
`endif

endmodule
